// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: operation codes, result classes,
// divider states and pipeline control constants.
package ex_stage_pkg;

  localparam logic [7:0] AluOpNop  = 8'b0000_0000;
  localparam logic [7:0] AluOpAnd  = 8'b0010_0100;
  localparam logic [7:0] AluOpOr   = 8'b0010_0101;
  localparam logic [7:0] AluOpXor  = 8'b0010_0110;
  localparam logic [7:0] AluOpNor  = 8'b0010_0111;
  localparam logic [7:0] AluOpSll  = 8'b0111_1100;
  localparam logic [7:0] AluOpSrl  = 8'b0000_0010;
  localparam logic [7:0] AluOpSra  = 8'b0000_0011;
  localparam logic [7:0] AluOpSlt  = 8'b0010_1010;
  localparam logic [7:0] AluOpSltu = 8'b0010_1011;
  localparam logic [7:0] AluOpAddu = 8'b0010_0001;
  localparam logic [7:0] AluOpSubu = 8'b0010_0011;
  localparam logic [7:0] AluOpMfhi = 8'b0001_0000;
  localparam logic [7:0] AluOpMthi = 8'b0001_0001;
  localparam logic [7:0] AluOpMflo = 8'b0001_0010;
  localparam logic [7:0] AluOpMtlo = 8'b0001_0011;
  localparam logic [7:0] AluOpDiv  = 8'b0001_1010;
  localparam logic [7:0] AluOpDivu = 8'b0001_1011;

  localparam logic [2:0] AluSelNop        = 3'b000;
  localparam logic [2:0] AluSelLogic      = 3'b001;
  localparam logic [2:0] AluSelShift      = 3'b010;
  localparam logic [2:0] AluSelMove       = 3'b011;
  localparam logic [2:0] AluSelArith      = 3'b100;
  localparam logic [2:0] AluSelJumpBranch = 3'b110;

  localparam logic       Stop         = 1'b1;
  localparam logic       NoStop       = 1'b0;
  localparam logic       WriteEnable  = 1'b1;
  localparam logic       WriteDisable = 1'b0;
  localparam logic [4:0] NOPRegAddr   = 5'b00000;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_stage_div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle on magnitudes,
// sign fixup applied to the held result. result = {remainder, quotient}.
module ex_stage_div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  div_state_e  r_state, w_state_d;
  logic [5:0]  r_cnt, w_cnt_d;
  logic [31:0] r_rem, w_rem_d;
  logic [31:0] r_quo, w_quo_d;
  logic [31:0] r_div, w_div_d;
  logic        r_neg_q, w_neg_q_d;
  logic        r_neg_r, w_neg_r_d;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Quotient bits shift out of the top of r_quo into the partial remainder.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rem_d   = r_rem;
    w_quo_d   = r_quo;
    w_div_d   = r_div;
    w_neg_q_d = r_neg_q;
    w_neg_r_d = r_neg_r;
    unique case (r_state)
      DivFree: begin
        if (start && !annul) begin
          w_neg_q_d = signed_div & (opdata1[31] ^ opdata2[31]);
          w_neg_r_d = signed_div & opdata1[31];
          w_cnt_d   = '0;
          w_rem_d   = '0;
          w_quo_d   = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
          w_div_d   = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
          w_state_d = (opdata2 == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul) begin
          w_state_d = DivFree;
        end else begin
          w_quo_d   = '0;
          w_rem_d   = '0;
          w_state_d = DivEnd;
        end
      end
      DivOn: begin
        if (annul) begin
          w_state_d = DivFree;
        end else begin
          if (!w_diff[32]) begin
            w_rem_d = w_diff[31:0];
            w_quo_d = {r_quo[30:0], 1'b1};
          end else begin
            w_rem_d = w_shift[31:0];
            w_quo_d = {r_quo[30:0], 1'b0};
          end
          w_cnt_d = r_cnt + 6'd1;
          if (r_cnt == 6'(DIV_CYCLES - 1)) begin
            w_state_d = DivEnd;
          end
        end
      end
      DivEnd: begin
        if (annul || !start) begin
          w_state_d = DivFree;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DivFree;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_rem   <= w_rem_d;
      r_quo   <= w_quo_d;
      r_div   <= w_div_d;
      r_neg_q <= w_neg_q_d;
      r_neg_r <= w_neg_r_d;
    end
  end

  assign w_quo_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;
  assign result    = {w_rem_fix, w_quo_fix};
  assign ready     = (r_state == DivEnd);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU results, HI/LO registers and the
// stall-generating multi-cycle divider.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_address_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] inst_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] r_hi, r_lo;
  logic [31:0] w_logic, w_shift, w_arith, w_move;
  logic        w_is_div, w_div_start, w_div_ready, w_no_stop;
  logic [63:0] w_div_result;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5:4], stall[2:0]};
  assign w_no_stop      = (stall[3] == NoStop);
  assign w_is_div       = (aluop_i == AluOpDiv) || (aluop_i == AluOpDivu);
  // Dropping start in END (when the stage may advance) returns the divider to FREE.
  assign w_div_start    = w_is_div & ~(w_div_ready & w_no_stop);

  ex_stage_div_unit #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_unit (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .signed_div(aluop_i == AluOpDiv),
    .opdata1   (reg1_i),
    .opdata2   (reg2_i),
    .annul     (~w_is_div),
    .result    (w_div_result),
    .ready     (w_div_ready)
  );

  always_comb begin
    w_logic = '0;
    w_shift = '0;
    w_arith = '0;
    w_move  = '0;
    case (aluop_i)
      AluOpOr:   w_logic = reg1_i | reg2_i;
      AluOpAnd:  w_logic = reg1_i & reg2_i;
      AluOpXor:  w_logic = reg1_i ^ reg2_i;
      AluOpNor:  w_logic = ~(reg1_i | reg2_i);
      AluOpSll:  w_shift = reg2_i << reg1_i[4:0];
      AluOpSrl:  w_shift = reg2_i >> reg1_i[4:0];
      AluOpSra:  w_shift = $signed(reg2_i) >>> reg1_i[4:0];
      AluOpAddu: w_arith = reg1_i + reg2_i;
      AluOpSubu: w_arith = reg1_i - reg2_i;
      AluOpSlt:  w_arith = ($signed(reg1_i) < $signed(reg2_i)) ? 32'd1 : 32'd0;
      AluOpSltu: w_arith = (reg1_i < reg2_i) ? 32'd1 : 32'd0;
      AluOpMfhi: w_move  = r_hi;
      AluOpMflo: w_move  = r_lo;
      default: ;
    endcase
  end

  always_comb begin
    wd_o              = wd_i;
    wreg_o            = wreg_i;
    wdata_o           = '0;
    is_in_delayslot_o = is_in_delayslot_i;
    inst_o            = inst_i;
    stallreq_o        = w_is_div & ~w_div_ready;
    case (alusel_i)
      AluSelLogic:      wdata_o = w_logic;
      AluSelShift:      wdata_o = w_shift;
      AluSelMove:       wdata_o = w_move;
      AluSelArith:      wdata_o = w_arith;
      AluSelJumpBranch: wdata_o = link_address_i;
      default:          wreg_o  = WriteDisable;
    endcase
    if (aluop_i == AluOpMthi || aluop_i == AluOpMtlo) begin
      wreg_o = WriteDisable;
    end
    if (rst) begin
      wd_o              = NOPRegAddr;
      wreg_o            = WriteDisable;
      wdata_o           = '0;
      is_in_delayslot_o = 1'b0;
      inst_o            = '0;
      stallreq_o        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_no_stop) begin
      if (w_is_div && w_div_ready) begin
        r_hi <= w_div_result[63:32];
        r_lo <= w_div_result[31:0];
      end else if (aluop_i == AluOpMthi) begin
        r_hi <= reg1_i;
      end else if (aluop_i == AluOpMtlo) begin
        r_lo <= reg1_i;
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
